qkv_read_sequencer: RTL and testbench
=====================================

// Module: qkv_read_sequencer
// PURPOSE
// Sequences the Q/K/V projection read stream after the host loads SRAMs over ICB.
// On a start command it reads input SRAM (32x96 int8) and each of six weight banks
// (wq0,wq1,wk0,wk1,wv0,wv1, 96x48 int8 each, column-major) and streams
// {input word, weight word} beat pairs to the 8-lane dot-product MAC.
// It sits between the ICB register block (CONTROL/STATUS) and the SRAM read ports.
// PARAMETERS
// ROWS   32  input tokens (rows of X)
// COLS   48  output columns per weight bank
// KW     12  64-bit words per 96-element vector (96/8)
// NBANK  6   weight banks, order wq0,wq1,wk0,wk1,wv0,wv1
// AW     12  SRAM address width
// DW     64  SRAM data width (8 x int8)
// PORTS
// clk          in   1          clock
// rst_n        in   1          synchronous reset, active-low
// ctrl         in   32         CONTROL reg: [0] start (level), [1] done_clr, [2] abort
// status       out  32         [0] busy, [1] done (sticky), [2] start_err (sticky), rest 0
// host_lock    out  1          1 while busy: host SRAM writes must be held off
// in_csbn      out  1          input SRAM chip select, active-low
// in_raddr     out  AW         input SRAM read address
// in_rdata     in   DW         input SRAM read data, valid 1 cycle after in_csbn=0
// w_csbn       out  NBANK      weight SRAM chip selects, active-low, at most one low
// w_raddr      out  AW         weight SRAM read address (shared by all banks)
// w_rdata      in   NBANK*DW   weight read data, bank b at [b*DW +: DW], 1-cycle latency
// beat_valid   out  1          beat available to MAC
// mac_ready    in   1          MAC accepts beat when beat_valid & mac_ready
// beat_in      out  DW         X[row, 8kw +: 8]
// beat_w       out  DW         W_bank[8kw +: 8, col]
// beat_first   out  1          kw==0 (clear accumulator)
// beat_last    out  1          kw==KW-1 (emit result)
// beat_bank    out  3          bank index of beat
// beat_row     out  5          row index of beat
// beat_col     out  6          column index of beat
// BEHAVIOUR
// - Reset: status=0, host_lock=0, in_csbn=1, w_csbn=all 1, raddrs=0, beat_valid=0,
//   beat_* data/tags=0, FIFO empty, counters 0, FSM IDLE, ctrl[0] edge register=0.
// - start = ctrl[0] & ~ctrl0_q (rising edge, ctrl0_q registered every cycle).
// - FSM IDLE->ISSUE on start: clears done, counters to 0, busy=1, host_lock=1.
//   start while busy: ignored, start_err<=1. done_clr=1 clears done and start_err.
// - Loop order outer->inner: bank(0..5), row(0..31), col(0..47), kw(0..11);
//   110592 beats total. in_raddr=row*KW+kw; w_raddr=col*KW+kw (max 383 / 575).
// - ISSUE: read issued (in_csbn=0, w_csbn[bank]=0) in a cycle iff credit:
//   fifo_count + inflight - pop < 2 (pop = beat_valid & mac_ready). Counters advance
//   only on issue. After final beat issued -> DRAIN.
// - Read cycle c: data captured at end of c+1 with bank/row/col/kw tags (delayed
//   1 cycle) into 2-entry FIFO; beat_valid earliest in cycle c+2. w_rdata muxed by
//   delayed bank. With mac_ready held 1: 1 beat/cycle, no bubbles.
// - First beat_valid 3 cycles after the cycle ctrl[0] is first sampled high.
// - Beat outputs = FIFO head; stable while beat_valid & ~mac_ready.
// - DRAIN -> DONE when FIFO empty and inflight=0; DONE (1 cycle): done<=1, busy<=0,
//   host_lock<=0 -> IDLE.
// - Abort (ctrl[2]=1) in ISSUE/DRAIN: next cycle IDLE, FIFO flushed, beat_valid=0,
//   chip selects high, busy=0, done unchanged (0); in-flight read data discarded.
//   Abort in IDLE: no effect. Abort has priority over start in same cycle.
// - Reset mid-run returns everything to reset values next cycle.
// TESTING
// - Start, mac_ready=1: 110592 beats, consecutive; first beat bank0,row0,col0,kw0,
//   in_raddr=0/w_raddr=0; last beat bank5,row31,col47,kw11; done=1, busy=0 after.
// - Data tags: bank2 w word 17 = known pattern -> beat with bank2,col1,kw5 carries
//   it; every beat_first at kw0, beat_last at kw11 (9216 each).
// - mac_ready random 50%: no beat lost/duplicated, beat held stable while stalled,
//   FIFO never >2, total still 110592.
// - mac_ready=0 for 20 cycles from first beat: exactly 2 reads issued, then stall;
//   release -> stream resumes in order.
// - Start pulse mid-run -> start_err=1, sequence unaffected; done_clr clears both.
// - Abort at beat 5000 -> beat_valid=0 and chip selects high next cycle, busy=0,
//   done=0; new start restarts at bank0,row0,col0,kw0.

Source files
------------

// File: rtl/qkv_read_sequencer.sv
// Streams {X word, W word} beat pairs from the input and six weight SRAMs to the MAC.
// A read lands in the 2-entry FIFO one cycle after issue; issue stops while FIFO + in-flight would exceed 2.

module qkv_fifo2 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic [1:0]   count
);
   logic [W-1:0] mem [2];
   logic         wr_ptr;
   logic         rd_ptr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else if (flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   assign dout = mem[rd_ptr];
endmodule

module qkv_read_sequencer #(
   parameter int ROWS  = 32,
   parameter int COLS  = 48,
   parameter int KW    = 12,
   parameter int NBANK = 6,
   parameter int AW    = 12,
   parameter int DW    = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [31:0]         ctrl,
   output logic [31:0]         status,
   output logic                host_lock,
   output logic                in_csbn,
   output logic [AW-1:0]       in_raddr,
   input  logic [DW-1:0]       in_rdata,
   output logic [NBANK-1:0]    w_csbn,
   output logic [AW-1:0]       w_raddr,
   input  logic [NBANK*DW-1:0] w_rdata,
   output logic                beat_valid,
   input  logic                mac_ready,
   output logic [DW-1:0]       beat_in,
   output logic [DW-1:0]       beat_w,
   output logic                beat_first,
   output logic                beat_last,
   output logic [2:0]          beat_bank,
   output logic [4:0]          beat_row,
   output logic [5:0]          beat_col
);
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   typedef struct packed {
      logic [DW-1:0] in_dat;
      logic [DW-1:0] w_dat;
      logic          first;
      logic          last;
      logic [2:0]    bank;
      logic [4:0]    row;
      logic [5:0]    col;
   } beat_t;

   state_t        state;
   state_t        nstate;
   logic          ctrl0_q;
   logic          start;
   logic          done_clr;
   logic          abort;
   logic          busy;
   logic          done_q;
   logic          err_q;
   logic [2:0]    bank_cnt;
   logic [4:0]    row_cnt;
   logic [5:0]    col_cnt;
   logic [3:0]    kw_cnt;
   logic          rd_q;
   logic [2:0]    bank_q;
   logic [4:0]    row_q;
   logic [5:0]    col_q;
   logic [3:0]    kw_q;
   logic [1:0]    fifo_count;
   logic [2:0]    occ;
   logic          credit;
   logic          issue;
   logic          last_beat;
   logic          pop;
   logic          push;
   logic          flush;
   logic          launch;
   logic [DW-1:0] w_sel;
   beat_t         push_dat;
   beat_t         head;
   logic          unused_ctrl;

   assign start       = ctrl[0] & ~ctrl0_q;
   assign done_clr    = ctrl[1];
   assign abort       = ctrl[2];
   assign unused_ctrl = ^ctrl[31:3];
   assign launch      = (state == IDLE) && start && !abort;

   // Occupancy the FIFO would reach if every read in flight lands and nothing more pops.
   assign pop       = beat_valid & mac_ready;
   assign occ       = {1'b0, fifo_count} + {2'b0, rd_q} - {2'b0, pop};
   assign credit    = occ < 3'd2;
   assign issue     = (state == ISSUE) && !abort && credit;
   assign last_beat = (bank_cnt == 3'(NBANK-1)) && (row_cnt == 5'(ROWS-1)) &&
                      (col_cnt == 6'(COLS-1)) && (kw_cnt == 4'(KW-1));
   assign flush     = abort && ((state == ISSUE) || (state == DRAIN));
   assign push      = rd_q && !flush;

   assign in_raddr = AW'(row_cnt) * AW'(KW) + AW'(kw_cnt);
   assign w_raddr  = AW'(col_cnt) * AW'(KW) + AW'(kw_cnt);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= nstate;
      end
   end

   always_comb begin
      nstate = state;
      case (state)
         IDLE:    if (launch) nstate = ISSUE;
         ISSUE:   if (abort) nstate = IDLE;
                  else if (issue && last_beat) nstate = DRAIN;
         DRAIN:   if (abort) nstate = IDLE;
                  else if ((fifo_count == 2'd0) && !rd_q) nstate = DONE;
         DONE:    nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state != IDLE);
      host_lock = busy;
      status    = {29'd0, err_q, done_q, busy};
      in_csbn   = ~issue;
      w_csbn    = issue ? ~(NBANK'(1) << bank_cnt) : '1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ctrl0_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         ctrl0_q <= ctrl[0];
         if (done_clr) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
         end
         if (launch) done_q <= 1'b0;
         if (busy && start) err_q <= 1'b1;
         if (state == DONE) done_q <= 1'b1;
      end
   end

   // Loop nest bank > row > col > kw, advanced once per issued read.
   always_ff @(posedge clk) begin
      if (!rst_n || launch) begin
         bank_cnt <= '0;
         row_cnt  <= '0;
         col_cnt  <= '0;
         kw_cnt   <= '0;
      end else if (issue) begin
         if (kw_cnt == 4'(KW-1)) begin
            kw_cnt <= '0;
            if (col_cnt == 6'(COLS-1)) begin
               col_cnt <= '0;
               if (row_cnt == 5'(ROWS-1)) begin
                  row_cnt  <= '0;
                  bank_cnt <= bank_cnt + 3'd1;
               end else begin
                  row_cnt <= row_cnt + 5'd1;
               end
            end else begin
               col_cnt <= col_cnt + 6'd1;
            end
         end else begin
            kw_cnt <= kw_cnt + 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_q   <= 1'b0;
         bank_q <= '0;
         row_q  <= '0;
         col_q  <= '0;
         kw_q   <= '0;
      end else begin
         rd_q   <= issue;
         bank_q <= bank_cnt;
         row_q  <= row_cnt;
         col_q  <= col_cnt;
         kw_q   <= kw_cnt;
      end
   end

   always_comb begin
      w_sel = '0;
      for (int b = 0; b < NBANK; b++) begin
         if (bank_q == 3'(b)) w_sel = w_rdata[b*DW +: DW];
      end
   end

   always_comb begin
      push_dat.in_dat = in_rdata;
      push_dat.w_dat  = w_sel;
      push_dat.first  = (kw_q == 4'd0);
      push_dat.last   = (kw_q == 4'(KW-1));
      push_dat.bank   = bank_q;
      push_dat.row    = row_q;
      push_dat.col    = col_q;
   end

   qkv_fifo2 #(
      .W($bits(beat_t))
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .push  (push),
      .pop   (pop),
      .din   (push_dat),
      .dout  (head),
      .count (fifo_count)
   );

   assign beat_valid = (fifo_count != 2'd0);
   assign beat_in    = head.in_dat;
   assign beat_w     = head.w_dat;
   assign beat_first = head.first;
   assign beat_last  = head.last;
   assign beat_bank  = head.bank;
   assign beat_row   = head.row;
   assign beat_col   = head.col;
endmodule

// File: tb/tb_qkv_read_sequencer.sv
// Bench for qkv_read_sequencer on a reduced row/column geometry with SRAM models and an in-order beat scoreboard.

module tb_qkv_read_sequencer;
   localparam int ROWS  = 4;
   localparam int COLS  = 6;
   localparam int KW    = 12;
   localparam int NBANK = 6;
   localparam int AW    = 12;
   localparam int DW    = 64;
   localparam int TOTAL = NBANK * ROWS * COLS * KW;
   localparam int NVEC  = NBANK * ROWS * COLS;
   localparam logic [63:0] KNOWN = 64'hDEAD_BEEF_CAFE_F00D;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [31:0]         ctrl;
   logic [31:0]         status;
   logic                host_lock;
   logic                in_csbn;
   logic [AW-1:0]       in_raddr;
   logic [DW-1:0]       in_rdata = '0;
   logic [NBANK-1:0]    w_csbn;
   logic [AW-1:0]       w_raddr;
   logic [NBANK*DW-1:0] w_rdata = '0;
   logic                beat_valid;
   logic                mac_ready;
   logic [DW-1:0]       beat_in;
   logic [DW-1:0]       beat_w;
   logic                beat_first;
   logic                beat_last;
   logic [2:0]          beat_bank;
   logic [4:0]          beat_row;
   logic [5:0]          beat_col;

   always #5 clk = ~clk;

   qkv_read_sequencer #(
      .ROWS(ROWS), .COLS(COLS), .KW(KW), .NBANK(NBANK), .AW(AW), .DW(DW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ctrl       (ctrl),
      .status     (status),
      .host_lock  (host_lock),
      .in_csbn    (in_csbn),
      .in_raddr   (in_raddr),
      .in_rdata   (in_rdata),
      .w_csbn     (w_csbn),
      .w_raddr    (w_raddr),
      .w_rdata    (w_rdata),
      .beat_valid (beat_valid),
      .mac_ready  (mac_ready),
      .beat_in    (beat_in),
      .beat_w     (beat_w),
      .beat_first (beat_first),
      .beat_last  (beat_last),
      .beat_bank  (beat_bank),
      .beat_row   (beat_row),
      .beat_col   (beat_col)
   );

   function automatic logic [63:0] in_pat(input int a);
      return {32'h1111_0000 + 32'(a), 32'hA5A5_0000 ^ (32'(a) * 32'd7)};
   endfunction

   function automatic logic [63:0] w_pat(input int b, input int a);
      if (b == 2 && a == 17) return KNOWN;
      return {8'(b + 1), 24'h0C0FFE, 32'(a) * 32'h9E37_79B9};
   endfunction

   always @(posedge clk) begin
      if (!in_csbn) in_rdata <= in_pat(int'(in_raddr));
      for (int b = 0; b < NBANK; b++) begin
         if (!w_csbn[b]) w_rdata[b*DW +: DW] <= w_pat(b, int'(w_raddr));
      end
   end

   int checks = 0;
   int errors = 0;
   int cyc = 0, issued = 0, accepted = 0, firsts = 0, lasts = 0, hits = 0;
   int first_acc = 0, last_acc = 0, max_in = 0, max_w = 0;
   logic [15:0]  first_tags = '0, last_tags = '0;
   logic         prev_stall = 1'b0;
   logic [143:0] prev_beat = '0;
   logic [143:0] exp_q[$];
   wire  [143:0] act = {beat_in, beat_w, beat_first, beat_last, beat_bank, beat_row, beat_col};

   task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic push_all();
      for (int b = 0; b < NBANK; b++)
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
               for (int k = 0; k < KW; k++)
                  exp_q.push_back({in_pat(r*KW + k), w_pat(b, c*KW + k), (k == 0), (k == KW-1),
                                   3'(b), 5'(r), 6'(c)});
   endtask

   task automatic clear_counts();
      issued = 0; accepted = 0; firsts = 0; lasts = 0; hits = 0; max_in = 0; max_w = 0;
      exp_q.delete();
   endtask

   // Monitor: scoreboard pops, stall stability, chip-select sanity, outstanding-read bound.
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         check("chip_select", in_csbn ? (w_csbn == '1) : ($countones(~w_csbn) == 1), 1);
         if (!in_csbn) begin
            issued++;
            if (int'(in_raddr) > max_in) max_in = int'(in_raddr);
            if (int'(w_raddr) > max_w) max_w = int'(w_raddr);
         end
         if (prev_stall) check("hold_stable", {beat_valid, act}, {1'b1, prev_beat});
         if (beat_valid && mac_ready) begin
            check("sb_nonempty", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("beat", act, exp_q.pop_front());
            if (accepted == 0) begin
               first_acc  = cyc;
               first_tags = act[15:0];
            end
            last_acc  = cyc;
            last_tags = act[15:0];
            accepted++;
            if (beat_first) firsts++;
            if (beat_last) lasts++;
            if (beat_bank == 3'd2 && beat_col == 6'd1 && beat_w == KNOWN) hits++;
         end
         check("outstanding_le2", (issued - accepted) <= 2, 1);
         prev_stall = beat_valid && !mac_ready;
         prev_beat  = act;
      end
   end

   task automatic wait_done(input int budget, input bit rnd);
      int n = 0;
      while (!status[1] && n < budget) begin
         @(posedge clk); #1;
         if (rnd) mac_ready = 1'($urandom_range(0, 1));
         n++;
      end
      check("done_within_budget", n < budget, 1);
   endtask

   task automatic do_done_clr();
      @(posedge clk); #1; ctrl = 32'h2;
      @(posedge clk); #1; ctrl = 32'h0;
      @(posedge clk); #1;
      check("done_clr", status, 0);
   endtask

   initial begin
      #600000;
      $display("FAIL global_timeout checks=%0d", checks);
      $fatal(1, "simulation time limit");
   end

   initial begin
      int n;
      rst_n = 1'b0; ctrl = '0; mac_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_status", status, 0);
      check("reset_pins", {host_lock, in_csbn, w_csbn, in_raddr, w_raddr, beat_valid},
            {1'b0, 1'b1, 6'h3F, 12'd0, 12'd0, 1'b0});
      check("reset_beat", act, 0);
      rst_n = 1'b1;

      // Full run, mac_ready high, with a start pulse while busy.
      @(posedge clk); #1;
      clear_counts(); push_all();
      ctrl = 32'h1; mac_ready = 1'b1;
      n = 0;
      while (!beat_valid && n < 10) begin @(posedge clk); #1; n++; end
      check("first_beat_latency", n, 3);
      check("busy_lock", {status[2:0], host_lock}, 4'b0011);
      repeat (100) begin @(posedge clk); #1; end
      ctrl = 32'h0;
      @(posedge clk); #1; ctrl = 32'h1;
      @(posedge clk); #1;
      check("start_err_set", status[2:0], 3'b101);
      wait_done(4000, 1'b0);
      check("run1_status", status, 32'h6);
      check("run1_count", accepted, TOTAL);
      check("run1_sb_empty", exp_q.size(), 0);
      check("run1_first_last", {firsts, lasts}, {NVEC, NVEC});
      check("run1_known_pattern", hits, ROWS);
      check("run1_no_bubbles", last_acc - first_acc, TOTAL - 1);
      check("run1_first_tags", first_tags, 16'h8000);
      check("run1_last_tags", last_tags, {1'b0, 1'b1, 3'd5, 5'(ROWS-1), 6'(COLS-1)});
      check("run1_max_addr", {max_in, max_w}, {ROWS*KW - 1, COLS*KW - 1});
      do_done_clr();

      // MAC stalled from the first beat for 20 cycles.
      clear_counts(); push_all();
      ctrl = 32'h1; mac_ready = 1'b0;
      n = 0;
      while (!beat_valid && n < 10) begin @(posedge clk); #1; n++; end
      check("stall_first_latency", n, 3);
      repeat (20) begin @(posedge clk); #1; end
      check("stall_reads_issued", issued, 2);
      check("stall_valid_held", beat_valid, 1);
      mac_ready = 1'b1;
      wait_done(4000, 1'b0);
      check("stall_count", accepted, TOTAL);
      check("stall_status", status[1:0], 2'b10);
      check("stall_sb_empty", exp_q.size(), 0);
      do_done_clr();

      // Random 50% backpressure.
      clear_counts(); push_all();
      ctrl = 32'h1;
      wait_done(10000, 1'b1);
      mac_ready = 1'b1;
      check("rand_count", accepted, TOTAL);
      check("rand_status", status[1:0], 2'b10);
      check("rand_sb_empty", exp_q.size(), 0);
      do_done_clr();

      // Abort after 500 beats, then restart from the top.
      clear_counts(); push_all();
      ctrl = 32'h1;
      n = 0;
      while (accepted < 500 && n < 2000) begin @(posedge clk); #1; n++; end
      check("abort_reach_500", accepted >= 500, 1);
      ctrl = 32'h5;
      @(posedge clk); #1;
      check("abort_pins", {beat_valid, in_csbn, w_csbn, status}, {1'b0, 1'b1, 6'h3F, 32'h0});
      ctrl = 32'h0;
      exp_q.delete();
      n = accepted;
      repeat (5) begin @(posedge clk); #1; end
      check("abort_no_stale", {beat_valid, accepted}, {1'b0, n});
      clear_counts(); push_all();
      ctrl = 32'h1;
      wait_done(4000, 1'b0);
      check("restart_count", accepted, TOTAL);
      check("restart_first_tags", first_tags, 16'h8000);
      check("restart_status", status[1:0], 2'b10);
      do_done_clr();

      // Reset in the middle of a run.
      clear_counts(); push_all();
      ctrl = 32'h1;
      repeat (50) begin @(posedge clk); #1; end
      rst_n = 1'b0; ctrl = 32'h0;
      @(posedge clk); #1;
      check("midrst_status", status, 0);
      check("midrst_pins", {host_lock, in_csbn, w_csbn, in_raddr, w_raddr, beat_valid},
            {1'b0, 1'b1, 6'h3F, 12'd0, 12'd0, 1'b0});
      check("midrst_beat", act, 0);
      rst_n = 1'b1;
      exp_q.delete();
      repeat (3) begin @(posedge clk); #1; end
      check("midrst_idle", {beat_valid, in_csbn, status[0]}, 3'b010);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
